// File: rtl/fcc.sv
// Flow-control credit counters for the five output directions of a NoC router.
// Each direction keeps a saturating free-slot count; its credit-enable is high while the count is non-zero.
module fcc #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic n_incr_i,
  input  logic s_incr_i,
  input  logic e_incr_i,
  input  logic w_incr_i,
  input  logic l_incr_i,
  input  logic n_decr_i,
  input  logic s_decr_i,
  input  logic e_decr_i,
  input  logic w_decr_i,
  input  logic l_decr_i,
  output logic credit_en_north_o,
  output logic credit_en_south_o,
  output logic credit_en_east_o,
  output logic credit_en_west_o,
  output logic credit_en_local_o
);

  localparam int unsigned NDIR = 5;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [NDIR-1:0] incr;
  logic [NDIR-1:0] decr;
  logic [NDIR-1:0] en_c;

  // Direction order: north, south, east, west, local (bit 0 .. bit 4).
  assign incr = {l_incr_i, w_incr_i, e_incr_i, s_incr_i, n_incr_i};
  assign decr = {l_decr_i, w_decr_i, e_decr_i, s_decr_i, n_decr_i};

  for (genvar g = 0; g < NDIR; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_nxt;

    // Saturating up/down; a simultaneous return and consume cancel out.
    always_comb begin
      cnt_nxt = cnt_d;
      case ({incr[g], decr[g]})
        2'b10: if (cnt_d != FULL) cnt_nxt = cnt_d + CNT_W'(1);
        2'b01: if (cnt_d != '0)   cnt_nxt = cnt_d - CNT_W'(1);
        default: cnt_nxt = cnt_d;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_d <= FULL;
      else        cnt_d <= cnt_nxt;
    end

    // Decoded from the counter register only, so no input-to-output path.
    assign en_c[g] = (cnt_d != '0);
  end

  assign credit_en_north_o = en_c[0];
  assign credit_en_south_o = en_c[1];
  assign credit_en_east_o  = en_c[2];
  assign credit_en_west_o  = en_c[3];
  assign credit_en_local_o = en_c[4];

endmodule

// File: tb/tb_fcc.sv
// Self-checking bench for fcc: directed corner cases plus random traffic
// compared against a per-direction free-slot model.
module tb_fcc;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] incr = '0;
  logic [4:0] decr = '0;
  logic [4:0] en;

  int model [5];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fcc #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .n_incr_i(incr[0]), .s_incr_i(incr[1]), .e_incr_i(incr[2]),
    .w_incr_i(incr[3]), .l_incr_i(incr[4]),
    .n_decr_i(decr[0]), .s_decr_i(decr[1]), .e_decr_i(decr[2]),
    .w_decr_i(decr[3]), .l_decr_i(decr[4]),
    .credit_en_north_o(en[0]), .credit_en_south_o(en[1]),
    .credit_en_east_o(en[2]), .credit_en_west_o(en[3]),
    .credit_en_local_o(en[4])
  );

  // Free slots cannot exceed the buffer depth nor drop below zero.
  task automatic model_update(input logic [4:0] inc, input logic [4:0] dec);
    for (int i = 0; i < 5; i++) begin
      if (inc[i] && !dec[i]) model[i] = (model[i] + 1 > DEPTH) ? DEPTH : model[i] + 1;
      if (dec[i] && !inc[i]) model[i] = (model[i] - 1 < 0) ? 0 : model[i] - 1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) model[i] = DEPTH;
  endtask

  task automatic check_all(input string tag);
    logic exp_bit;
    for (int i = 0; i < 5; i++) begin
      exp_bit = (model[i] != 0);
      vectors++;
      assert (en[i] === exp_bit) else begin
        miscompares++;
        $error("FAIL %s dir%0d observed=%b expected=%b (model count %0d)",
               tag, i, en[i], exp_bit, model[i]);
      end
    end
  endtask

  // Apply one cycle of inputs, let the edge sample them, then check after the edge.
  task automatic step(input logic [4:0] inc, input logic [4:0] dec, input string tag);
    incr = inc;
    decr = dec;
    @(posedge clk);
    model_update(inc, dec);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [4:0] ri;
    logic [4:0] rd;

    // Reset held over a few edges, then released synchronously.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    rst_n = 1'b1;
    step('0, '0, "post_reset_idle");

    // Drain north: enable stays high for three edges, falls on the fourth.
    for (int k = 0; k < 4; k++) step(5'b00001 & '1, 5'b00000, "nop") ;
    for (int k = 0; k < 4; k++) step(5'b00000, 5'b00001, "drain_north");
    step('0, 5'b00001, "north_underflow");
    step(5'b00001, '0, "north_recover");
    step('0, 5'b00001, "north_back_to_zero");

    // East: empty it, then simultaneous incr/decr must hold at 0.
    for (int k = 0; k < 4; k++) step('0, 5'b00100, "drain_east");
    for (int k = 0; k < 3; k++) step(5'b00100, 5'b00100, "east_both_at_0");
    for (int k = 0; k < 4; k++) step(5'b00100, '0, "refill_east");
    for (int k = 0; k < 3; k++) step(5'b00100, 5'b00100, "east_both_at_full");
    for (int k = 0; k < 3; k++) step(5'b00100, 5'b00000, "east_over_full");
    for (int k = 0; k < 4; k++) step('0, 5'b00100, "east_no_phantom");

    // Local: saturate at full, then exactly four consumes empty it.
    for (int k = 0; k < 3; k++) step(5'b10000, '0, "local_overflow");
    for (int k = 0; k < 4; k++) step('0, 5'b10000, "local_drain");

    // Drain west and south while north/east/local see random traffic.
    for (int k = 0; k < 6; k++) begin
      ri = 5'($urandom) & 5'b10101;
      rd = (5'($urandom) & 5'b10101) | 5'b01010;
      step(ri, rd, "drain_ws_random");
    end

    // Fully random traffic on every direction.
    for (int k = 0; k < 300; k++) begin
      ri = 5'($urandom);
      rd = 5'($urandom);
      step(ri, rd, "random");
    end

    // Make sure at least one counter is empty before the async reset.
    for (int k = 0; k < 4; k++) step('0, 5'b00010, "pre_reset_drain");
    incr = '0;
    decr = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset_immediate");
    @(negedge clk);
    check_all("async_reset_held");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Counts must be back at full: three consumes keep enable, fourth clears it.
    for (int k = 0; k < 4; k++) step('0, 5'b11111, "post_reset_drain_all");
    step('1, '0, "post_reset_refill");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fcc.md
# fcc

Flow-control credit (FCC) block for one NoC router. It keeps one credit counter per output direction (north, south, east, west, local). Each counter tracks the free buffer slots in the downstream input buffer. The block raises a per-direction credit-enable flag whenever at least one credit is available. The router's switch allocator uses these flags to gate flit forwarding.

## Interface
Parameters:
- `BUF_DEPTH`, default 4: credits per direction; equals the downstream input-buffer depth; legal range 1..15.
- `CNT_W`, default `$clog2(BUF_DEPTH+1)` (3 for the default): counter width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `n_incr_i` / `s_incr_i` / `e_incr_i` / `w_incr_i` / `l_incr_i`  in  1 each  credit return from the downstream router in that direction (one slot freed).
- `n_decr_i` / `s_decr_i` / `e_decr_i` / `w_decr_i` / `l_decr_i`  in  1 each  credit consumed (one flit sent out in that direction this cycle).
- `credit_en_north_o` / `credit_en_south_o` / `credit_en_east_o` / `credit_en_west_o` / `credit_en_local_o`  out  1 each  high when the corresponding counter is non-zero (sending allowed).

## Operation
- There are five independent identical channels. A channel is one counter `cnt_d[CNT_W-1:0]` plus its incr/decr pair. There is no cross-direction interaction.
- Reset (`rst_n`=0):
  - every counter is set to `BUF_DEPTH` (downstream buffers start empty);
  - every `credit_en_*_o` is therefore 1.
- Per rising edge, for each direction:
  - incr=1, decr=0: cnt+1, saturating at `BUF_DEPTH` (an extra credit at full is dropped).
  - incr=0, decr=1: cnt-1, saturating at 0 (a decrement at 0 is ignored; an upstream protocol violation).
  - incr=1, decr=1: cnt unchanged, including at 0 and at `BUF_DEPTH`.
  - incr=0, decr=0: hold.
- Output rule: `credit_en_<dir>_o = (cnt_d != 0)`. It is driven combinationally from the counter register only, with no combinational path from any input.
- Inputs are sampled synchronously. The bench drives them 1 time unit after the clock edge, so they are stable at the next edge.

## Timing
- Latency: an incr/decr sampled at edge k updates the counter at edge k; `credit_en_*_o` reflects the new value right after edge k.
- The last credit is consumed with decr at edge k (cnt 1→0). `credit_en` falls after edge k, so the allocator sees it low for the cycle after k.
- Credit returned at 0: incr at edge k (cnt 0→1) raises `credit_en` after edge k.
- Asserting `rst_n` low mid-operation forces all counters to `BUF_DEPTH` and all outputs to 1 immediately, without waiting for a clock edge.
- Deasserting `rst_n` is synchronous to `clk` by system convention. The first update happens on the first edge with `rst_n`=1.
- Throughput: one incr and one decr per direction per cycle, sustained indefinitely.

## Test plan
- Reset check:
  - assert `rst_n`=0, then release;
  - all five `credit_en_*_o`=1;
  - internal counts = 4.
- Drain north:
  - `n_decr_i`=1 for 4 cycles, then 0;
  - `credit_en_north_o` stays 1 through the first 3 edges and reads 0 after the 4th;
  - other four outputs stay 1.
- Underflow/recover:
  - from north=0, drive a 5th `n_decr_i` → output stays 0, count stays 0;
  - then one `n_incr_i` → `credit_en_north_o`=1 after that edge, count=1.
- Simultaneous incr and decr:
  - from east=0, drive both `e_incr_i`=1 and `e_decr_i`=1 for 3 cycles → `credit_en_east_o` stays 0;
  - repeat at east=4 → stays 4, output 1.
- Overflow saturation:
  - at local=4, `l_incr_i`=1 for 3 cycles → count stays 4;
  - then 4 `l_decr_i` cycles → `credit_en_local_o` 0 after the 4th (no phantom credits).
- Independence plus async reset:
  - drain west and south to 0 while driving random incr/decr on the other directions;
  - pulse `rst_n` low between clock edges → all outputs 1 immediately, all counts = 4.
